// File: rtl/heart_pkg.sv
// Shared types and default constants for the heartbeat interval meter.
package heart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam int PERIOD_W_DEF         = 16;
    localparam int REFRACTORY_TICKS_DEF = 250;
    localparam int TIMEOUT_TICKS_DEF    = 3000;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The output pulse lasts exactly one clk cycle per rising edge of level.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rise_reg;

    // The pulse is registered so both channels see identical, fixed latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= level;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/beat_interval_meter.sv
// Measures ticks between accepted heartbeats with refractory rejection and
// loss-of-signal timeout; intervals are published on a valid/ready port.
module beat_interval_meter
    import heart_pkg::*;
#(
    parameter int PERIOD_W         = PERIOD_W_DEF,
    parameter int REFRACTORY_TICKS = REFRACTORY_TICKS_DEF,
    parameter int TIMEOUT_TICKS    = TIMEOUT_TICKS_DEF
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                tick_clk,
    input  logic                beat_in,
    output logic [PERIOD_W-1:0] interval_ticks,
    output logic                interval_valid,
    input  logic                interval_ready,
    output logic                beat_pulse,
    output logic                timeout_pulse,
    output logic                no_signal,
    output logic                overrun
);

    localparam logic [PERIOD_W-1:0] REFRACT_LIM = PERIOD_W'(REFRACTORY_TICKS);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LIM = PERIOD_W'(TIMEOUT_TICKS);

    logic [1:0] raw;
    logic [1:0] rise;
    logic       tick;
    logic       beat_edge;

    assign raw = {beat_in, tick_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            sync_rise_detect u_sync (
                .clk   (clk_in),
                .rst_n (reset),
                .level (raw[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    assign tick      = rise[0];
    assign beat_edge = rise[1];

    state_t              state_reg;
    logic [PERIOD_W-1:0] count_reg;
    logic [PERIOD_W-1:0] count_inc;
    logic [PERIOD_W-1:0] interval_reg;
    logic                valid_reg;
    logic                beat_pulse_reg;
    logic                timeout_pulse_reg;
    logic                no_signal_reg;
    logic                overrun_reg;

    assign count_inc = count_reg + PERIOD_W'(1);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            count_reg         <= '0;
            interval_reg      <= '0;
            valid_reg         <= 1'b0;
            beat_pulse_reg    <= 1'b0;
            timeout_pulse_reg <= 1'b0;
            no_signal_reg     <= 1'b1;
            overrun_reg       <= 1'b0;
        end else begin
            beat_pulse_reg    <= 1'b0;
            timeout_pulse_reg <= 1'b0;
            // A publish later in this block overrides the consume.
            if (valid_reg && interval_ready)
                valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (beat_edge) begin
                        count_reg      <= '0;
                        beat_pulse_reg <= 1'b1;
                        no_signal_reg  <= 1'b0;
                        state_reg      <= REFRACT;
                    end
                end
                REFRACT: begin
                    if (tick) begin
                        count_reg <= count_inc;
                        if (count_inc >= REFRACT_LIM)
                            state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    // The beat takes priority over a coincident tick or timeout.
                    if (beat_edge) begin
                        interval_reg   <= count_reg;
                        valid_reg      <= 1'b1;
                        if (valid_reg && !interval_ready)
                            overrun_reg <= 1'b1;
                        count_reg      <= '0;
                        beat_pulse_reg <= 1'b1;
                        state_reg      <= REFRACT;
                    end else if (tick) begin
                        if (count_inc >= TIMEOUT_LIM) begin
                            count_reg         <= '0;
                            timeout_pulse_reg <= 1'b1;
                            no_signal_reg     <= 1'b1;
                            state_reg         <= IDLE;
                        end else begin
                            count_reg <= count_inc;
                        end
                    end
                end
                default: begin
                    count_reg     <= '0;
                    no_signal_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign interval_ticks = interval_reg;
    assign interval_valid = valid_reg;
    assign beat_pulse     = beat_pulse_reg;
    assign timeout_pulse  = timeout_pulse_reg;
    assign no_signal      = no_signal_reg;
    assign overrun        = overrun_reg;

endmodule

// File: tb/tb_beat_interval_meter.sv
// Directed bench for beat_interval_meter: refractory 4, timeout 20, tick = 10 clk_in.
module tb_beat_interval_meter;

    localparam int PW = 16;

    logic          clk_in         = 1'b0;
    logic          reset          = 1'b0;
    logic          tick_clk       = 1'b0;
    logic          beat_in        = 1'b0;
    logic          interval_ready = 1'b1;
    logic [PW-1:0] interval_ticks;
    logic          interval_valid;
    logic          beat_pulse;
    logic          timeout_pulse;
    logic          no_signal;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int bp_cnt = 0;
    int to_cnt = 0;

    beat_interval_meter #(
        .PERIOD_W         (PW),
        .REFRACTORY_TICKS (4),
        .TIMEOUT_TICKS    (20)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .tick_clk       (tick_clk),
        .beat_in        (beat_in),
        .interval_ticks (interval_ticks),
        .interval_valid (interval_valid),
        .interval_ready (interval_ready),
        .beat_pulse     (beat_pulse),
        .timeout_pulse  (timeout_pulse),
        .no_signal      (no_signal),
        .overrun        (overrun)
    );

    always #5 clk_in = ~clk_in;
    always #50 tick_clk = ~tick_clk;

    always @(negedge clk_in) begin
        if (beat_pulse)    bp_cnt++;
        if (timeout_pulse) to_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "time limit exceeded");
    end

    // Returns a few cycles after a tick edge, well clear of the tick's own update.
    task automatic wait_tick(input int n);
        repeat (n) begin
            @(posedge tick_clk);
            repeat (3) @(posedge clk_in);
            #1;
        end
    endtask

    // Returns just after the edge on which the beat reaches the outputs.
    task automatic fire_beat;
        beat_in = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        beat_in = 1'b0;
    endtask

    task automatic fire_beat_on_tick;
        @(posedge tick_clk);
        beat_in = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        beat_in = 1'b0;
    endtask

    task automatic apply_reset;
        @(posedge clk_in);
        #1;
        reset   = 1'b0;
        beat_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [21:0] obs;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in);
            #1;
            beat_in = ~beat_in;
        end
        obs = {interval_ticks, interval_valid, beat_pulse, timeout_pulse, overrun, no_signal, 1'b0};
        checks++;
        if (obs !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs, {16'd0, 6'b000010});
        end
        @(posedge clk_in);
        #1;
        reset  = 1'b1;
        bp_cnt = 0;
        to_cnt = 0;
        wait_tick(25);
        obs = {interval_ticks, interval_valid, beat_pulse, timeout_pulse, overrun, no_signal, 1'b0};
        checks++;
        if (obs !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle_outputs: got %h required %h", obs, {16'd0, 6'b000010});
        end
        checks++;
        if (bp_cnt != 0 || to_cnt != 0) begin
            errors++;
            $display("FAIL idle_pulses: got beat=%0d timeout=%0d required 0 0", bp_cnt, to_cnt);
        end
    endtask

    task automatic test_interval;
        apply_reset();
        wait_tick(1);
        fire_beat();
        checks++;
        if (beat_pulse !== 1'b1 || interval_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_beat: got pulse=%b valid=%b required 1 0", beat_pulse, interval_valid);
        end
        wait_tick(12);
        beat_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (interval_valid !== 1'b0 || beat_pulse !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%b pulse=%b required 0 0", interval_valid, beat_pulse);
        end
        @(posedge clk_in);
        #1;
        beat_in = 1'b0;
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd12 || beat_pulse !== 1'b1) begin
            errors++;
            $display("FAIL interval_12: got valid=%b ticks=%0d pulse=%b required 1 12 1",
                     interval_valid, interval_ticks, beat_pulse);
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (interval_valid !== 1'b0 || interval_ticks !== 16'd12) begin
            errors++;
            $display("FAIL consume: got valid=%b ticks=%0d required 0 12", interval_valid, interval_ticks);
        end
    endtask

    task automatic test_refractory;
        apply_reset();
        wait_tick(1);
        fire_beat();
        wait_tick(2);
        fire_beat();
        checks++;
        if (beat_pulse !== 1'b0 || interval_valid !== 1'b0) begin
            errors++;
            $display("FAIL refractory_ignore: got pulse=%b valid=%b required 0 0", beat_pulse, interval_valid);
        end
        wait_tick(7);
        fire_beat();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd9) begin
            errors++;
            $display("FAIL interval_9: got valid=%b ticks=%0d required 1 9", interval_valid, interval_ticks);
        end
    endtask

    task automatic test_timeout;
        apply_reset();
        wait_tick(1);
        fire_beat();
        to_cnt = 0;
        wait_tick(19);
        repeat (5) @(posedge clk_in);
        #1;
        checks++;
        if (to_cnt != 0 || no_signal !== 1'b0) begin
            errors++;
            $display("FAIL before_timeout: got timeouts=%0d no_signal=%b required 0 0", to_cnt, no_signal);
        end
        wait_tick(1);
        repeat (5) @(posedge clk_in);
        #1;
        checks++;
        if (to_cnt != 1 || no_signal !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got timeout_cycles=%0d no_signal=%b required 1 1", to_cnt, no_signal);
        end
        wait_tick(1);
        fire_beat();
        checks++;
        if (beat_pulse !== 1'b1 || interval_valid !== 1'b0 || no_signal !== 1'b0) begin
            errors++;
            $display("FAIL rearm_beat: got pulse=%b valid=%b no_signal=%b required 1 0 0",
                     beat_pulse, interval_valid, no_signal);
        end
        wait_tick(6);
        fire_beat();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd6) begin
            errors++;
            $display("FAIL fresh_interval: got valid=%b ticks=%0d required 1 6", interval_valid, interval_ticks);
        end
    endtask

    task automatic test_overrun;
        apply_reset();
        interval_ready = 1'b0;
        wait_tick(1);
        fire_beat();
        wait_tick(8);
        fire_beat();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd8 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL hold_8: got valid=%b ticks=%0d overrun=%b required 1 8 0",
                     interval_valid, interval_ticks, overrun);
        end
        wait_tick(10);
        fire_beat();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd10 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_10: got valid=%b ticks=%0d overrun=%b required 1 10 1",
                     interval_valid, interval_ticks, overrun);
        end
        interval_ready = 1'b1;
        @(posedge clk_in);
        #1;
        checks++;
        if (interval_valid !== 1'b0 || overrun !== 1'b1 || interval_ticks !== 16'd10) begin
            errors++;
            $display("FAIL overrun_sticky: got valid=%b overrun=%b ticks=%0d required 0 1 10",
                     interval_valid, overrun, interval_ticks);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        interval_ready = 1'b1;
        wait_tick(1);
        fire_beat();
        wait_tick(7);
        fire_beat_on_tick();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd7 || beat_pulse !== 1'b1) begin
            errors++;
            $display("FAIL tick_beat_collide: got valid=%b ticks=%0d pulse=%b required 1 7 1",
                     interval_valid, interval_ticks, beat_pulse);
        end
        interval_ready = 1'b0;
        wait_tick(5);
        fire_beat();
        checks++;
        if (interval_valid !== 1'b1 || interval_ticks !== 16'd5) begin
            errors++;
            $display("FAIL after_collide: got valid=%b ticks=%0d required 1 5", interval_valid, interval_ticks);
        end
        wait_tick(5);
        reset = 1'b0;
        #1;
        checks++;
        if (interval_valid !== 1'b0 || no_signal !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b no_signal=%b overrun=%b required 0 1 0",
                     interval_valid, no_signal, overrun);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        interval_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_interval();
        test_refractory();
        test_timeout();
        test_overrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
